// File: rtl/ssd1306_spi_sequencer.sv
// SSD1306-class 4-wire SPI sequencer: panel reset pulse, ROM-driven init stream, then
// host bytes over valid/ready, each byte framed with its own D/C level.
module ssd1306_spi_sequencer #(
    parameter int CLKS_PER_HALF_BIT = 4,
    parameter int SPI_MODE          = 0,
    parameter int RES_LOW_CYCLES    = 1000,
    parameter int RES_WAIT_CYCLES   = 1000,
    parameter int INIT_LEN          = 32,
    parameter int ROM_ADDR_W        = 8
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    output logic [ROM_ADDR_W-1:0] o_Rom_Addr,
    input  logic [7:0]            i_Rom_Data,
    input  logic [7:0]            i_TX_Byte,
    input  logic                  i_TX_DC,
    input  logic                  i_TX_DV,
    output logic                  o_TX_Ready,
    output logic                  o_Init_Done,
    output logic                  o_SPI_Clk,
    output logic                  o_SPI_MOSI,
    output logic                  o_SPI_CS_n,
    output logic                  o_RES,
    output logic                  o_DC,
    output logic [7:0]            o_Last_Byte
);

    localparam logic CPOL    = ((SPI_MODE / 2) % 2) == 1;
    localparam logic CPHA    = (SPI_MODE % 2) == 1;
    localparam int   RES_MAX = (RES_LOW_CYCLES > RES_WAIT_CYCLES) ? RES_LOW_CYCLES : RES_WAIT_CYCLES;
    localparam int   RC_W    = $clog2(RES_MAX + 1);
    localparam int   HC_W    = $clog2(CLKS_PER_HALF_BIT + 1);
    localparam logic [ROM_ADDR_W-1:0] LAST_ADDR = ROM_ADDR_W'(INIT_LEN == 0 ? 0 : INIT_LEN - 1);

    localparam logic [2:0] S_RES_LOW  = 3'd0;
    localparam logic [2:0] S_RES_WAIT = 3'd1;
    localparam logic [2:0] S_INIT_GAP = 3'd2;
    localparam logic [2:0] S_IDLE     = 3'd3;
    localparam logic [2:0] S_XFER     = 3'd4;

    localparam logic [1:0] P_SETUP = 2'd0;
    localparam logic [1:0] P_SHIFT = 2'd1;
    localparam logic [1:0] P_HOLD  = 2'd2;

    logic [2:0]            state_q, state_d;
    logic [1:0]            phase_q, phase_d;
    logic [RC_W-1:0]       res_cnt_q, res_cnt_d;
    logic [HC_W-1:0]       hcnt_q, hcnt_d;
    logic [3:0]            bcnt_q, bcnt_d;
    logic [7:0]            byte_q, byte_d;
    logic                  dc_q, dc_d;
    logic [ROM_ADDR_W-1:0] addr_q, addr_d;
    logic                  done_q, done_d;
    logic [7:0]            last_q, last_d;

    logic                  half_end;
    logic                  in_frame;
    logic [2:0]            bit_idx;
    logic                  mosi;

    assign half_end = (hcnt_q == HC_W'(CLKS_PER_HALF_BIT - 1));
    assign in_frame = (state_q == S_XFER);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        res_cnt_d = res_cnt_q;
        hcnt_d    = hcnt_q;
        bcnt_d    = bcnt_q;
        byte_d    = byte_q;
        dc_d      = dc_q;
        addr_d    = addr_q;
        done_d    = done_q;
        last_d    = last_q;
        case (state_q)
            S_RES_LOW: begin
                res_cnt_d = res_cnt_q + 1'b1;
                if (res_cnt_q == RC_W'(RES_LOW_CYCLES - 1)) begin
                    res_cnt_d = '0;
                    state_d   = S_RES_WAIT;
                end
            end
            S_RES_WAIT: begin
                res_cnt_d = res_cnt_q + 1'b1;
                if (res_cnt_q == RC_W'(RES_WAIT_CYCLES - 1)) begin
                    res_cnt_d = '0;
                    if (INIT_LEN == 0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_XFER;
                        phase_d = P_SETUP;
                        hcnt_d  = '0;
                        byte_d  = i_Rom_Data;
                        dc_d    = 1'b0;
                    end
                end
            end
            S_INIT_GAP: begin
                state_d = S_XFER;
                phase_d = P_SETUP;
                hcnt_d  = '0;
                byte_d  = i_Rom_Data;
                dc_d    = 1'b0;
            end
            S_IDLE: begin
                if (i_TX_DV) begin
                    state_d = S_XFER;
                    phase_d = P_SETUP;
                    hcnt_d  = '0;
                    byte_d  = i_TX_Byte;
                    dc_d    = i_TX_DC;
                end
            end
            S_XFER: begin
                hcnt_d = half_end ? '0 : hcnt_q + 1'b1;
                if (half_end) begin
                    case (phase_q)
                        P_SETUP: begin
                            phase_d = P_SHIFT;
                            bcnt_d  = '0;
                        end
                        P_SHIFT: begin
                            if (bcnt_q == 4'd15) phase_d = P_HOLD;
                            else                 bcnt_d  = bcnt_q + 1'b1;
                        end
                        default: begin
                            // Frame complete: init frames step the ROM, host frames go back to IDLE.
                            last_d = byte_q;
                            if (done_q) begin
                                state_d = S_IDLE;
                            end else if (addr_q == LAST_ADDR) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                addr_d  = addr_q + 1'b1;
                                state_d = S_INIT_GAP;
                            end
                        end
                    endcase
                end
            end
            default: state_d = S_RES_LOW;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q   <= S_RES_LOW;
            phase_q   <= P_SETUP;
            res_cnt_q <= '0;
            hcnt_q    <= '0;
            bcnt_q    <= '0;
            byte_q    <= '0;
            dc_q      <= 1'b0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            res_cnt_q <= res_cnt_d;
            hcnt_q    <= hcnt_d;
            bcnt_q    <= bcnt_d;
            byte_q    <= byte_d;
            dc_q      <= dc_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            last_q    <= last_d;
        end
    end

    // Bit index per half-period: CPHA=1 moves on leading edges (k/2), CPHA=0 on trailing ((k+1)/2).
    always_comb begin
        bit_idx = '0;
        mosi    = 1'b0;
        if (in_frame) begin
            case (phase_q)
                P_SETUP: mosi = CPHA ? 1'b0 : byte_q[7];
                P_SHIFT: begin
                    if (CPHA)                 bit_idx = bcnt_q[3:1];
                    else if (bcnt_q == 4'd15) bit_idx = 3'd7;
                    else                      bit_idx = bcnt_q[3:1] + {2'b00, bcnt_q[0]};
                    mosi = byte_q[3'd7 - bit_idx];
                end
                default: mosi = byte_q[0];
            endcase
        end
    end

    assign o_SPI_Clk   = (in_frame && phase_q == P_SHIFT) ? (CPOL ^ ~bcnt_q[0]) : CPOL;
    assign o_SPI_MOSI  = mosi;
    assign o_SPI_CS_n  = ~in_frame;
    assign o_DC        = in_frame & dc_q;
    assign o_RES       = (state_q != S_RES_LOW);
    assign o_TX_Ready  = (state_q == S_IDLE);
    assign o_Init_Done = done_q;
    assign o_Rom_Addr  = addr_q;
    assign o_Last_Byte = last_q;

endmodule

// File: tb/tb_ssd1306_spi_sequencer.sv
// Directed bench: mode-0 instance with a 3-byte init ROM, and a mode-3 instance with no init.
module tb_ssd1306_spi_sequencer;

    typedef struct {
        logic [7:0] b;
        logic       dc;
        int         len;
        int         nbits;
        logic       dcbad;
    } frame_t;

    logic clk;
    int   checks = 0;
    int   errors = 0;
    int   n;
    logic quiet;
    frame_t qa[$];
    frame_t qb[$];

    // Instance A: mode 0, init ROM {AE,D5,80}
    logic       rst_a, dv_a, dc_in_a, ready_a, done_a, sclk_a, mosi_a, cs_a, res_a, dc_a;
    logic [7:0] addr_a, rom_a, byte_a, last_a;
    // Instance B: mode 3, no init
    logic       rst_b, dv_b, dc_in_b, ready_b, done_b, sclk_b, mosi_b, cs_b, res_b, dc_b;
    logic [3:0] addr_b;
    logic [7:0] rom_b, byte_b, last_b;

    ssd1306_spi_sequencer #(
        .CLKS_PER_HALF_BIT(2), .SPI_MODE(0), .RES_LOW_CYCLES(8),
        .RES_WAIT_CYCLES(4), .INIT_LEN(3), .ROM_ADDR_W(8)
    ) u_dut_a (
        .i_Clk(clk), .i_Rst_L(rst_a), .o_Rom_Addr(addr_a), .i_Rom_Data(rom_a),
        .i_TX_Byte(byte_a), .i_TX_DC(dc_in_a), .i_TX_DV(dv_a), .o_TX_Ready(ready_a),
        .o_Init_Done(done_a), .o_SPI_Clk(sclk_a), .o_SPI_MOSI(mosi_a), .o_SPI_CS_n(cs_a),
        .o_RES(res_a), .o_DC(dc_a), .o_Last_Byte(last_a)
    );

    ssd1306_spi_sequencer #(
        .CLKS_PER_HALF_BIT(2), .SPI_MODE(3), .RES_LOW_CYCLES(8),
        .RES_WAIT_CYCLES(4), .INIT_LEN(0), .ROM_ADDR_W(4)
    ) u_dut_b (
        .i_Clk(clk), .i_Rst_L(rst_b), .o_Rom_Addr(addr_b), .i_Rom_Data(rom_b),
        .i_TX_Byte(byte_b), .i_TX_DC(dc_in_b), .i_TX_DV(dv_b), .o_TX_Ready(ready_b),
        .o_Init_Done(done_b), .o_SPI_Clk(sclk_b), .o_SPI_MOSI(mosi_b), .o_SPI_CS_n(cs_b),
        .o_RES(res_b), .o_DC(dc_b), .o_Last_Byte(last_b)
    );

    always_comb begin
        case (addr_a)
            8'd0:    rom_a = 8'hAE;
            8'd1:    rom_a = 8'hD5;
            8'd2:    rom_a = 8'h80;
            default: rom_a = 8'h00;
        endcase
    end
    assign rom_b = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_a(input string tag, input logic [7:0] b, input logic dc);
        frame_t f;
        check({tag, "_seen"}, qa.size() > 0, 1);
        if (qa.size() > 0) begin
            f = qa.pop_front();
            check({tag, "_byte"}, f.b, b);
            check({tag, "_dc"}, f.dc, dc);
            check({tag, "_len"}, f.len, 36);
            check({tag, "_nbits"}, f.nbits, 8);
            check({tag, "_dc_stable"}, f.dcbad, 0);
        end
    endtask

    task automatic expect_b(input string tag, input logic [7:0] b, input logic dc);
        frame_t f;
        check({tag, "_seen"}, qb.size() > 0, 1);
        if (qb.size() > 0) begin
            f = qb.pop_front();
            check({tag, "_byte"}, f.b, b);
            check({tag, "_dc"}, f.dc, dc);
            check({tag, "_len"}, f.len, 36);
            check({tag, "_nbits"}, f.nbits, 8);
        end
    endtask

    // Panel-side receivers: both modes sample MOSI on rising SCLK.
    initial begin : mon_a
        logic   prev_cs, prev_sclk;
        frame_t cur;
        prev_cs = 1'b1;
        prev_sclk = 1'b0;
        cur = '{default: 0};
        forever begin
            @(negedge clk);
            if (cs_a === 1'b0) begin
                if (prev_cs) begin
                    cur = '{default: 0};
                    cur.dc = dc_a;
                end
                cur.len++;
                if (dc_a !== cur.dc) cur.dcbad = 1'b1;
                if (!prev_sclk && sclk_a) begin
                    cur.b = {cur.b[6:0], mosi_a};
                    cur.nbits++;
                end
            end else if (!prev_cs && res_a) begin
                qa.push_back(cur);
            end
            prev_cs = cs_a;
            prev_sclk = sclk_a;
        end
    end

    initial begin : mon_b
        logic   prev_cs, prev_sclk;
        frame_t cur;
        prev_cs = 1'b1;
        prev_sclk = 1'b1;
        cur = '{default: 0};
        forever begin
            @(negedge clk);
            if (cs_b === 1'b0) begin
                if (prev_cs) begin
                    cur = '{default: 0};
                    cur.dc = dc_b;
                end
                cur.len++;
                if (!prev_sclk && sclk_b) begin
                    cur.b = {cur.b[6:0], mosi_b};
                    cur.nbits++;
                end
            end else if (!prev_cs && res_b) begin
                qb.push_back(cur);
            end
            prev_cs = cs_b;
            prev_sclk = sclk_b;
        end
    end

    initial begin
        rst_a = 1'b0; dv_a = 1'b0; dc_in_a = 1'b0; byte_a = 8'h00;
        rst_b = 1'b0; dv_b = 1'b0; dc_in_b = 1'b0; byte_b = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_res", res_a, 0);
        check("rst_cs", cs_a, 1);
        check("rst_sclk", sclk_a, 0);
        check("rst_mosi", mosi_a, 0);
        check("rst_dc", dc_a, 0);
        check("rst_ready", ready_a, 0);
        check("rst_done", done_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_last", last_a, 0);
        check("rst_sclk_m3", sclk_b, 1);

        // T1: reset pulse timing and init stream
        rst_a = 1'b1;
        n = 0;
        while (res_a == 1'b0 && n < 100) begin n++; @(negedge clk); end
        check("res_low_cycles", n, 8);
        n = 0;
        while (res_a && cs_a && n < 100) begin n++; @(negedge clk); end
        check("res_wait_cycles", n, 4);
        n = 1;
        while (!done_a && n < 1000) begin @(negedge clk); n++; end
        check("init_done_cycle", n, 111);
        @(negedge clk);
        check("init_frames", qa.size(), 3);
        expect_a("init0", 8'hAE, 1'b0);
        expect_a("init1", 8'hD5, 1'b0);
        expect_a("init2", 8'h80, 1'b0);
        check("init_addr_hold", addr_a, 2);
        check("init_last", last_a, 8'h80);
        check("idle_ready", ready_a, 1);
        check("idle_sclk", sclk_a, 0);

        // T2: single host data byte
        dv_a = 1'b1; byte_a = 8'hA5; dc_in_a = 1'b1;
        @(negedge clk);
        dv_a = 1'b0;
        check("t2_ready_drop", ready_a, 0);
        check("t2_cs_low", cs_a, 0);
        check("t2_dc_high", dc_a, 1);
        n = 0;
        while (!ready_a && n < 200) begin @(negedge clk); n++; end
        check("t2_ready_return", n, 36);
        check("t2_last", last_a, 8'hA5);
        check("t2_cs_idle", cs_a, 1);
        @(negedge clk);
        expect_a("t2", 8'hA5, 1'b1);
        check("t2_addr_hold", addr_a, 2);

        // T4: held DV, back-to-back bytes
        dv_a = 1'b1; byte_a = 8'h01; dc_in_a = 1'b0;
        @(negedge clk);
        byte_a = 8'h02;
        n = 0;
        while (!ready_a && n < 200) begin @(negedge clk); n++; end
        check("t4_ready_return", n, 36);
        check("t4_gap_cs", cs_a, 1);
        @(negedge clk);
        check("t4_restart_cs", cs_a, 0);
        dv_a = 1'b0;
        n = 0;
        while (!ready_a && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        expect_a("t4_b0", 8'h01, 1'b0);
        expect_a("t4_b1", 8'h02, 1'b0);
        check("t4_last", last_a, 8'h02);

        // T5: reset during bit 4 of the second init byte
        qa.delete();
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        n = 0;
        while (!(addr_a == 8'd1 && cs_a == 1'b0) && n < 500) begin @(negedge clk); n++; end
        check("t5_reached_byte1", addr_a, 1);
        repeat (18) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        check("t5_cs", cs_a, 1);
        check("t5_res", res_a, 0);
        check("t5_done", done_a, 0);
        check("t5_addr", addr_a, 0);
        check("t5_last", last_a, 0);
        rst_a = 1'b1;
        qa.delete();
        n = 0;
        while (res_a == 1'b0 && n < 100) begin n++; @(negedge clk); end
        check("t5_res_low_cycles", n, 8);
        n = 0;
        while (!done_a && n < 1000) begin @(negedge clk); n++; end
        @(negedge clk);
        check("t5_done_again", done_a, 1);
        check("t5_frames", qa.size(), 3);
        expect_a("t5_init0", 8'hAE, 1'b0);
        expect_a("t5_init1", 8'hD5, 1'b0);
        expect_a("t5_init2", 8'h80, 1'b0);

        // T6 + T3: mode 3 instance without init
        rst_b = 1'b1;
        n = 0;
        quiet = 1'b1;
        while (!ready_b && n < 100) begin
            if (sclk_b !== 1'b1 || cs_b !== 1'b1) quiet = 1'b0;
            @(negedge clk);
            n++;
        end
        check("t6_ready_cycles", n, 12);
        check("t6_quiet", quiet, 1);
        check("t6_done", done_b, 1);
        check("t6_addr", addr_b, 0);
        dv_b = 1'b1; byte_b = 8'h3C; dc_in_b = 1'b1;
        @(negedge clk);
        dv_b = 1'b0;
        check("t3_ready_drop", ready_b, 0);
        n = 0;
        while (!ready_b && n < 200) begin @(negedge clk); n++; end
        check("t3_ready_return", n, 36);
        @(negedge clk);
        expect_b("t3", 8'h3C, 1'b1);
        check("t3_sclk_idle", sclk_b, 1);
        check("t3_mosi_idle", mosi_b, 0);
        check("t3_last", last_b, 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
